// File: rtl/mem_req_master.sv
// mem_req_master: FIFO-buffered memory request master with ready timeout and read responses.
// Define MEM_REQ_STAT_EN to add saturating wr_cnt_o/rd_cnt_o completion counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

module mem_req_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_wr_rd_i,
  input  logic [`ADDR_WIDTH-1:0] req_addr_i,
  input  logic [`WIDTH-1:0]      req_wdata_i,
  output logic                   valid_o,
  output logic                   wr_rd_o,
  output logic [`ADDR_WIDTH-1:0] addr_o,
  output logic [`WIDTH-1:0]      wdata_o,
  input  logic                   ready_i,
  input  logic [`WIDTH-1:0]      rdata_i,
  output logic                   rsp_valid_o,
  output logic [`WIDTH-1:0]      rsp_rdata_o,
  output logic [`ADDR_WIDTH-1:0] rsp_addr_o,
  output logic                   err_o
`ifdef MEM_REQ_STAT_EN
  ,
  output logic [15:0]            wr_cnt_o,
  output logic [15:0]            rd_cnt_o
`endif
);

  localparam int AW      = `ADDR_WIDTH;
  localparam int DW      = `WIDTH;
  localparam int ENTRY_W = 1 + AW + DW;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e               state_r;
  logic [ENTRY_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [7:0]           wait_r;
  logic [ENTRY_W-1:0]   head_s;
  logic                 head_wr_s;
  logic [AW-1:0]        head_addr_s;
  logic [DW-1:0]        head_wdata_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 complete_s;
  logic                 timeout_s;

  assign req_ready_o  = !rst_i && (count_r != DEPTH_C);
  assign push_s       = req_valid_i && req_ready_o;
  assign pop_s        = complete_s || timeout_s;
  assign head_s       = mem_r[rd_ptr_r];
  assign head_wr_s    = head_s[ENTRY_W-1];
  assign head_addr_s  = head_s[DW +: AW];
  assign head_wdata_s = head_s[DW-1:0];

  // ISSUE exit conditions; ready_i only matters while a request is on the bus
  always_comb begin
    complete_s = 1'b0;
    timeout_s  = 1'b0;
    if (state_r == ST_ISSUE) begin
      complete_s = ready_i;
      timeout_s  = !ready_i && (wait_r == WAIT_LAST);
    end else begin
      complete_s = 1'b0;
      timeout_s  = 1'b0;
    end
  end

  // Request storage; contents are never observed unless count_r covers them
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {req_wr_rd_i, req_addr_i, req_wdata_i};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Request channel FSM with registered bus and response outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      wait_r      <= 8'd0;
      valid_o     <= 1'b0;
      wr_rd_o     <= 1'b0;
      addr_o      <= {AW{1'b0}};
      wdata_o     <= {DW{1'b0}};
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= {DW{1'b0}};
      rsp_addr_o  <= {AW{1'b0}};
      err_o       <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      err_o       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          wait_r <= 8'd0;
          if (count_r != {CNT_W{1'b0}}) begin
            state_r <= ST_ISSUE;
            valid_o <= 1'b1;
            wr_rd_o <= head_wr_s;
            addr_o  <= head_addr_s;
            wdata_o <= head_wr_s ? head_wdata_s : {DW{1'b0}};
          end
        end
        ST_ISSUE: begin
          if (complete_s || timeout_s) begin
            state_r <= ST_GAP;
            valid_o <= 1'b0;
            wr_rd_o <= 1'b0;
            addr_o  <= {AW{1'b0}};
            wdata_o <= {DW{1'b0}};
            err_o   <= timeout_s;
            if (complete_s && !wr_rd_o) begin
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= rdata_i;
              rsp_addr_o  <= addr_o;
            end
          end else begin
            wait_r <= wait_r + 8'd1;
          end
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          valid_o <= 1'b0;
          wr_rd_o <= 1'b0;
          addr_o  <= {AW{1'b0}};
          wdata_o <= {DW{1'b0}};
        end
      endcase
    end
  end

`ifdef MEM_REQ_STAT_EN
  // Saturating counts of completed (not timed-out) transfers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_o <= 16'd0;
      rd_cnt_o <= 16'd0;
    end else begin
      if (complete_s && wr_rd_o && (wr_cnt_o != 16'hFFFF)) begin
        wr_cnt_o <= wr_cnt_o + 16'd1;
      end
      if (complete_s && !wr_rd_o && (rd_cnt_o != 16'hFFFF)) begin
        rd_cnt_o <= rd_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_master.sv
// Self-checking bench for mem_req_master: directed vector table, corner sequences,
// and randomized traffic against a transaction-level queue model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_mem_req_master;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int AW      = `ADDR_WIDTH;
  localparam int DW      = `WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_wr_rd_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          valid_o;
  logic          wr_rd_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          ready_i;
  logic [DW-1:0] rdata_i;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic [AW-1:0] rsp_addr_o;
  logic          err_o;
`ifdef MEM_REQ_STAT_EN
  logic [15:0]   wr_cnt_o;
  logic [15:0]   rd_cnt_o;
`endif

  mem_req_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_rd_i(req_wr_rd_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .valid_o(valid_o), .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .ready_i(ready_i), .rdata_i(rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_addr_o(rsp_addr_o),
    .err_o(err_o)
`ifdef MEM_REQ_STAT_EN
    , .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          req_ready;
    logic          valid;
    logic          wr_rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] rsp_addr;
    logic          err;
  } outs_t;

  typedef struct {
    logic          rv;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rdy;
    logic [DW-1:0] rdata;
    outs_t         exp;
  } vec_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: accepted-but-unfinished requests in order, head is the one on the bus
  req_t          q[$];
  int            t_issue;     // -1 when nothing is on the bus, else stalled cycles so far
  int            since_done;  // cycles since the last request left the bus
  logic          m_rsp_valid;
  logic [DW-1:0] m_rsp_rdata;
  logic [AW-1:0] m_rsp_addr;
  logic          m_err;
  int            m_wr_cnt, m_rd_cnt;

  task automatic model_reset();
    q.delete();
    t_issue     = -1;
    since_done  = 100;
    m_rsp_valid = 1'b0;
    m_rsp_rdata = '0;
    m_rsp_addr  = '0;
    m_err       = 1'b0;
    m_wr_cnt    = 0;
    m_rd_cnt    = 0;
  endtask

  task automatic model_edge();
    bit   push;
    req_t nr;
    push     = req_valid_i && (q.size() != DEPTH);
    nr.wr    = req_wr_rd_i;
    nr.addr  = req_addr_i;
    nr.wdata = req_wdata_i;
    m_rsp_valid = 1'b0;
    m_err       = 1'b0;
    if (t_issue >= 0) begin
      if (ready_i) begin
        if (q[0].wr) begin
          if (m_wr_cnt < 65535) m_wr_cnt++;
        end else begin
          m_rsp_valid = 1'b1;
          m_rsp_rdata = rdata_i;
          m_rsp_addr  = q[0].addr;
          if (m_rd_cnt < 65535) m_rd_cnt++;
        end
        void'(q.pop_front());
        t_issue    = -1;
        since_done = 0;
      end else if (t_issue + 1 == TIMEOUT) begin
        void'(q.pop_front());
        m_err      = 1'b1;
        t_issue    = -1;
        since_done = 0;
      end else begin
        t_issue++;
      end
    end else begin
      if (since_done >= 1 && q.size() > 0) t_issue = 0;
      if (since_done < 100) since_done++;
    end
    if (push) q.push_back(nr);
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    o = '0;
    o.req_ready = (q.size() != DEPTH);
    if (t_issue >= 0) begin
      o.valid = 1'b1;
      o.wr_rd = q[0].wr;
      o.addr  = q[0].addr;
      o.wdata = q[0].wr ? q[0].wdata : '0;
    end
    o.rsp_valid = m_rsp_valid;
    o.rsp_rdata = m_rsp_rdata;
    o.rsp_addr  = m_rsp_addr;
    o.err       = m_err;
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.req_ready = req_ready_o;
    o.valid     = valid_o;
    o.wr_rd     = wr_rd_o;
    o.addr      = addr_o;
    o.wdata     = wdata_o;
    o.rsp_valid = rsp_valid_o;
    o.rsp_rdata = rsp_rdata_o;
    o.rsp_addr  = rsp_addr_o;
    o.err       = err_o;
    return o;
  endfunction

  function automatic outs_t mk(input logic rr, input logic v, input logic wr, input int a,
                               input int wd, input logic rv, input int rd, input int ra,
                               input logic e);
    outs_t o;
    o.req_ready = rr;
    o.valid     = v;
    o.wr_rd     = wr;
    o.addr      = AW'(a);
    o.wdata     = DW'(wd);
    o.rsp_valid = rv;
    o.rsp_rdata = DW'(rd);
    o.rsp_addr  = AW'(ra);
    o.err       = e;
    return o;
  endfunction

  task automatic chk(input string name, input outs_t act, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: model advances at the edge, outputs are compared on the falling edge
  task automatic cycle(input string name);
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    chk(name, dut_outs(), model_outs());
`ifdef MEM_REQ_STAT_EN
    chk_int({name, "_wrcnt"}, longint'(wr_cnt_o), longint'(m_wr_cnt));
    chk_int({name, "_rdcnt"}, longint'(rd_cnt_o), longint'(m_rd_cnt));
`endif
  endtask

  // Cycle that drops req_valid_i once the request has been taken
  task automatic step(input string name);
    bit acc;
    acc = req_valid_i && (q.size() != DEPTH);
    cycle(name);
    if (acc) req_valid_i = 1'b0;
  endtask

  task automatic idle_inputs();
    req_valid_i = 1'b0;
    req_wr_rd_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    ready_i     = 1'b0;
    rdata_i     = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  vt[$];
    vec_t  v;
    outs_t zero;
    int    n_valid;
    int    n_err;
    bit    seen;
    int    p_ready;
    req_t  plan[$];
    req_t  r;

    zero = '0;
    rst_i = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    chk("reset_outputs", dut_outs(), zero);
    repeat (2) @(negedge clk_i);
    chk("reset_held", dut_outs(), zero);
    rst_i = 1'b0;

    // Write addr 3 / A5 with ready in its first ISSUE cycle, then read addr 3 returning A5
    v = '{1'b1, 1'b1, AW'(3), DW'(8'hA5), 1'b0, DW'(0), mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};    vt.push_back(v);
    v = '{1'b0, 1'b0, AW'(0), DW'(0), 1'b0, DW'(0), mk(1, 1, 1, 3, 8'hA5, 0, 0, 0, 0)};    vt.push_back(v);
    v = '{1'b0, 1'b0, AW'(0), DW'(0), 1'b1, DW'(0), mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};        vt.push_back(v);
    v = '{1'b0, 1'b0, AW'(0), DW'(0), 1'b0, DW'(0), mk(1, 0, 0, 0, 0, 0, 0, 0, 0)};        vt.push_back(v);
    v = '{1'b1, 1'b0, AW'(3), DW'(8'hFF), 1'b1, DW'(8'h77), mk(1, 0, 0, 0, 0, 0, 0, 0, 0)}; vt.push_back(v);
    v = '{1'b0, 1'b0, AW'(0), DW'(0), 1'b1, DW'(8'h77), mk(1, 1, 0, 3, 0, 0, 0, 0, 0)};    vt.push_back(v);
    v = '{1'b0, 1'b0, AW'(0), DW'(0), 1'b0, DW'(0), mk(1, 1, 0, 3, 0, 0, 0, 0, 0)};        vt.push_back(v);
    v = '{1'b0, 1'b0, AW'(0), DW'(0), 1'b1, DW'(8'hA5), mk(1, 0, 0, 0, 0, 1, 8'hA5, 3, 0)}; vt.push_back(v);
    v = '{1'b0, 1'b0, AW'(0), DW'(0), 1'b0, DW'(0), mk(1, 0, 0, 0, 0, 0, 8'hA5, 3, 0)};    vt.push_back(v);
    v = '{1'b0, 1'b0, AW'(0), DW'(0), 1'b0, DW'(0), mk(1, 0, 0, 0, 0, 0, 8'hA5, 3, 0)};    vt.push_back(v);
    for (int i = 0; i < vt.size(); i++) begin
      req_valid_i = vt[i].rv;
      req_wr_rd_i = vt[i].wr;
      req_addr_i  = vt[i].addr;
      req_wdata_i = vt[i].wdata;
      ready_i     = vt[i].rdy;
      rdata_i     = vt[i].rdata;
      cycle("table_model");
      chk($sformatf("table_row%0d", i), dut_outs(), vt[i].exp);
    end

    // Fill the FIFO with ready low, hold a 5th request, then let the head time out
    idle_inputs();
    n_valid = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1;
      req_wr_rd_i = 1'b1;
      req_addr_i  = AW'(8'h10 + i);
      req_wdata_i = DW'(8'h40 + i);
      cycle("fill");
      if (valid_o) n_valid++;
    end
    chk_int("full_after_4", longint'(req_ready_o), 0);
    req_addr_i  = AW'(8'h14);
    req_wdata_i = DW'(8'h44);
    step("fifth_held");
    if (valid_o) n_valid++;
    chk_int("fifth_still_held", longint'(req_ready_o), 0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step("timeout_wait");
      if (valid_o) n_valid++;
      if (err_o) seen = 1'b1;
    end
    chk_int("err_seen", longint'(seen), 1);
    chk_int("issue_cycles_before_err", n_valid, TIMEOUT);
    step("idle_after_gap");
    chk_int("idle_after_gap_valid", longint'(valid_o), 0);
    chk_int("err_one_cycle", longint'(err_o), 0);
    step("next_issue");
    chk_int("next_issue", longint'({valid_o, addr_o}), (longint'(1) << AW) | 64'h11);
    ready_i = 1'b1;
    for (int i = 0; i < 25; i++) step("drain");
    ready_i = 1'b0;

    // Reset while a request is in flight and two more are queued
    for (int i = 0; i < 3; i++) begin
      req_valid_i = 1'b1;
      req_wr_rd_i = 1'(i % 2);
      req_addr_i  = AW'(8'h20 + i);
      req_wdata_i = DW'(8'h60 + i);
      cycle("pre_reset_fill");
    end
    req_valid_i = 1'b0;
    cycle("pre_reset_issue");
    chk_int("in_flight_before_reset", longint'(valid_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("reset_mid_issue", dut_outs(), zero);
    model_reset();
    @(negedge clk_i);
    chk("reset_mid_issue_held", dut_outs(), zero);
    rst_i = 1'b0;
    n_err = 0;
    for (int i = 0; i < 6; i++) begin
      cycle("post_reset");
      if (valid_o || rsp_valid_o || err_o || !req_ready_o) n_err++;
    end
    chk_int("post_reset_quiet", n_err, 0);

    // Two writes, one read, one timed-out write
    r = '{1'b1, AW'(1), DW'(8'h11)}; plan.push_back(r);
    r = '{1'b1, AW'(2), DW'(8'h22)}; plan.push_back(r);
    r = '{1'b0, AW'(3), DW'(8'h33)}; plan.push_back(r);
    r = '{1'b1, AW'(4), DW'(8'h44)}; plan.push_back(r);
    rdata_i = DW'(8'h5A);
    n_err = 0;
    for (int i = 0; i < 80; i++) begin
      bit acc;
      if (plan.size() > 0) begin
        req_valid_i = 1'b1;
        req_wr_rd_i = plan[0].wr;
        req_addr_i  = plan[0].addr;
        req_wdata_i = plan[0].wdata;
      end else begin
        req_valid_i = 1'b0;
      end
      ready_i = (t_issue >= 0) && (q[0].addr != AW'(4));
      acc = req_valid_i && (q.size() != DEPTH);
      cycle("stats_seq");
      if (acc) void'(plan.pop_front());
      if (err_o) n_err++;
    end
    chk_int("stats_seq_err_pulses", n_err, 1);
    chk_int("stats_seq_model_wr", m_wr_cnt, 2);
    chk_int("stats_seq_model_rd", m_rd_cnt, 1);
`ifdef MEM_REQ_STAT_EN
    chk_int("wr_cnt_after_seq", longint'(wr_cnt_o), 2);
    chk_int("rd_cnt_after_seq", longint'(rd_cnt_o), 1);
`endif

    // Randomized traffic with phases of scarce and plentiful ready_i
    p_ready = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(3))
          0:       p_ready = 0;
          1:       p_ready = 10;
          2:       p_ready = 50;
          default: p_ready = 90;
        endcase
      end
      req_valid_i = ($urandom_range(99) < 50);
      req_wr_rd_i = 1'($urandom_range(1));
      req_addr_i  = AW'($urandom);
      req_wdata_i = DW'($urandom);
      ready_i     = ($urandom_range(99) < p_ready);
      rdata_i     = DW'($urandom);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
